// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_arbiter
//  Purpose  : Shares the single external memory port of the RISC-V virtual
//             system between NUM_PORTS requesters. One transaction is in
//             flight at a time. Each requester gets an accept pulse, a
//             response pulse and its tag back. A stalled external bus is
//             reported as an error response.
//  Options  : RISCV_MEM_ARB_RR_EN - round-robin among ports 1..NUM_PORTS-1
//             (port 0 always keeps absolute priority). When it is undefined,
//             fixed priority applies and the lowest index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
    parameter int NUM_PORTS   = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 11,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_valid_i,
    output logic [NUM_PORTS-1:0]            req_accept_o,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   req_wstrb_i,
    input  logic [NUM_PORTS*TAG_W-1:0]      req_tag_i,
    output logic [NUM_PORTS-1:0]            resp_valid_o,
    output logic [DATA_W-1:0]               resp_rdata_o,
    output logic                            resp_error_o,
    output logic [TAG_W-1:0]                resp_tag_o,
    output logic [ADDR_W-1:0]               ext_addr_o,
    output logic [DATA_W-1:0]               ext_wdata_o,
    output logic [DATA_W/8-1:0]             ext_wstrb_o,
    output logic                            ext_we_o,
    output logic                            ext_re_o,
    input  logic [DATA_W-1:0]               ext_rdata_i,
    input  logic                            ext_ready_i,
    input  logic                            ext_error_i,
    output logic                            busy_o
);

    localparam int C_STRB_W = DATA_W / 8;
    localparam int C_IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int C_CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [C_IDX_W-1:0]    grant_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [C_STRB_W-1:0]   wstrb_q;
    logic [TAG_W-1:0]      tag_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  error_q;
    logic [TAG_W-1:0]      resp_tag_q;

    logic                  w_any_req;
    logic [C_IDX_W-1:0]    w_grant;
    logic                  w_timeout;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [C_STRB_W-1:0]   w_sel_wstrb;
    logic [TAG_W-1:0]      w_sel_tag;

    assign w_any_req = |req_valid_i;

`ifdef RISCV_MEM_ARB_RR_EN
    // Pointer holds the port (1..NUM_PORTS-1) where the next round-robin search begins.
    logic [C_IDX_W-1:0]    rr_ptr_q;
    int                    w_idx;
    logic                  w_found;

    // Advance the pointer past each accepted non-zero grant; port 0 leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= C_IDX_W'(1);
        end else if (state_q == ST_IDLE && w_any_req && w_grant != '0) begin
            if (int'(w_grant) == NUM_PORTS - 1) begin
                rr_ptr_q <= C_IDX_W'(1);
            end else begin
                rr_ptr_q <= w_grant + C_IDX_W'(1);
            end
        end
    end

    // Port 0 first, otherwise the first requester found starting at the pointer.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (!req_valid_i[0]) begin
            for (int i = 0; i < NUM_PORTS - 1; i++) begin
                w_idx = int'(rr_ptr_q) + i;
                if (w_idx >= NUM_PORTS) begin
                    w_idx = w_idx - (NUM_PORTS - 1);
                end
                if (!w_found && req_valid_i[C_IDX_W'(w_idx)]) begin
                    w_found = 1'b1;
                    w_grant = C_IDX_W'(w_idx);
                end
            end
        end
    end
`else
    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        w_grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid_i[C_IDX_W'(i)]) begin
                w_grant = C_IDX_W'(i);
            end
        end
    end
`endif

    // Select the winning port's payload from the flattened request buses.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        w_sel_tag   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant == C_IDX_W'(p)) begin
                w_sel_addr  = req_addr_i[p*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata_i[p*DATA_W +: DATA_W];
                w_sel_wstrb = req_wstrb_i[p*C_STRB_W +: C_STRB_W];
                w_sel_tag   = req_tag_i[p*TAG_W +: TAG_W];
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT_CYC);
            logic [C_CNT_W-1:0] cnt_q;

            // Count BUSY cycles without ready; cleared on each accept and saturating at the limit.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (state_q == ST_IDLE && w_any_req) begin
                    cnt_q <= '0;
                end else if (state_q == ST_BUSY && !ext_ready_i && cnt_q != C_TIMEOUT) begin
                    cnt_q <= cnt_q + C_CNT_W'(1);
                end
            end

            assign w_timeout = (state_q == ST_BUSY) && (cnt_q == C_TIMEOUT);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Transaction FSM: capture the request on accept and the response on completion or timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            tag_q      <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            resp_tag_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any_req) begin
                        state_q <= ST_BUSY;
                        grant_q <= w_grant;
                        addr_q  <= w_sel_addr;
                        wdata_q <= w_sel_wdata;
                        wstrb_q <= w_sel_wstrb;
                        tag_q   <= w_sel_tag;
                    end
                end
                ST_BUSY: begin
                    // A ready in the same cycle as the timeout wins and gives a normal response.
                    if (ext_ready_i) begin
                        state_q    <= ST_RESP;
                        rdata_q    <= ext_rdata_i;
                        error_q    <= ext_error_i;
                        resp_tag_q <= tag_q;
                    end else if (w_timeout) begin
                        state_q    <= ST_RESP;
                        rdata_q    <= '0;
                        error_q    <= 1'b1;
                        resp_tag_q <= tag_q;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The accept pulse depends only on the current state and the request lines.
    always_comb begin
        req_accept_o = '0;
        if (state_q == ST_IDLE && w_any_req) begin
            req_accept_o[w_grant] = 1'b1;
        end
    end

    // The response pulse goes to the port that owns the transaction, for the single RESP cycle.
    always_comb begin
        resp_valid_o = '0;
        if (state_q == ST_RESP) begin
            resp_valid_o[grant_q] = 1'b1;
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_error_o = error_q;
    assign resp_tag_o   = resp_tag_q;

    assign busy_o       = (state_q != ST_IDLE);
    assign ext_addr_o   = (state_q == ST_BUSY) ? addr_q  : '0;
    assign ext_wdata_o  = (state_q == ST_BUSY) ? wdata_q : '0;
    assign ext_wstrb_o  = (state_q == ST_BUSY) ? wstrb_q : '0;
    assign ext_we_o     = (state_q == ST_BUSY) &&  (|wstrb_q);
    assign ext_re_o     = (state_q == ST_BUSY) && !(|wstrb_q);

endmodule
`default_nettype wire
